// File: rtl/otter_intc_csr_if.sv
// otter_intc_csr_if
// Bundles the control-FSM side of the OTTER CSR file / interrupt controller.
//   master : the control FSM (drives CSR write path, pc, int_check, mret_exec)
//   slave  : otter_intc_csr (returns csr_rd, int_taken, trap_target, mepc_out,
//            mie_global)
// Signals:
//   csr_we       CSR write strobe
//   csr_addr     CSR address, ir[31:20]
//   csr_wd       merged CSR write data (RW/RS/RC already applied)
//   pc           address of the next instruction; saved to mepc on a trap
//   int_check    instruction-boundary strobe; a trap may be taken this cycle
//   mret_exec    MRET executing this cycle
//   csr_rd       combinational read data for csr_addr
//   int_taken    trap accepted this cycle
//   trap_target  PC source for a trap
//   mepc_out     current mepc, PC source for MRET
//   mie_global   mstatus.MIE
interface otter_intc_csr_if;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [31:0] csr_wd;
  logic [31:0] pc;
  logic        int_check;
  logic        mret_exec;
  logic [31:0] csr_rd;
  logic        int_taken;
  logic [31:0] trap_target;
  logic [31:0] mepc_out;
  logic        mie_global;

  modport master (
    output csr_we, csr_addr, csr_wd, pc, int_check, mret_exec,
    input  csr_rd, int_taken, trap_target, mepc_out, mie_global
  );

  modport slave (
    input  csr_we, csr_addr, csr_wd, pc, int_check, mret_exec,
    output csr_rd, int_taken, trap_target, mepc_out, mie_global
  );
endinterface

// File: rtl/otter_intc_csr.sv
// otter_intc_csr
// Machine-mode CSR file plus an edge-latched, fixed-priority interrupt
// controller for the OTTER multicycle core.
// Implements mstatus (MIE/MPIE), mie, mtvec (direct/vectored), mepc, mcause
// and mip (write-1-to-clear). Source 0 has the highest priority.
// Ports:
//   clk       CPU clock, all state updates on the rising edge
//   rst       asynchronous active-high reset
//   i_irq_in  level interrupt lines, already synchronised to clk
//   bus       otter_intc_csr_if.slave (CSR write path, trap/MRET handshake)
module otter_intc_csr #(
  parameter int          NUM_IRQ     = 4,
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] i_irq_in,
  otter_intc_csr_if.slave    bus
);

  localparam logic [11:0] ADDR_MSTATUS = 12'h300;
  localparam logic [11:0] ADDR_MIE     = 12'h304;
  localparam logic [11:0] ADDR_MTVEC   = 12'h305;
  localparam logic [11:0] ADDR_MEPC    = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE  = 12'h342;
  localparam logic [11:0] ADDR_MIP     = 12'h344;

  logic               r_mstatMie;
  logic               r_mstatMpie;
  logic [NUM_IRQ-1:0] r_mieEn;
  logic [31:0]        r_mtvec;
  logic [31:0]        r_mepc;
  logic [31:0]        r_mcause;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_irqPrev;

  logic [NUM_IRQ-1:0] w_enPend;
  logic               w_req;
  logic [3:0]         w_sel;
  logic               w_taken;
  logic [31:0]        w_base;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_trapClr;
  logic [NUM_IRQ-1:0] w_w1cClr;
  logic [31:0]        w_csrRd;
  logic               w_wrMstatus;
  logic               w_wrMie;
  logic               w_wrMtvec;
  logic               w_wrMepc;
  logic               w_wrMcause;
  logic               w_wrMip;

  // Decode which implemented CSR (if any) the FSM is writing this cycle.
  assign w_wrMstatus = bus.csr_we && (bus.csr_addr == ADDR_MSTATUS);
  assign w_wrMie     = bus.csr_we && (bus.csr_addr == ADDR_MIE);
  assign w_wrMtvec   = bus.csr_we && (bus.csr_addr == ADDR_MTVEC);
  assign w_wrMepc    = bus.csr_we && (bus.csr_addr == ADDR_MEPC);
  assign w_wrMcause  = bus.csr_we && (bus.csr_addr == ADDR_MCAUSE);
  assign w_wrMip     = bus.csr_we && (bus.csr_addr == ADDR_MIP);

  // Interrupt request: any enabled pending source while MIE is set.
  assign w_enPend = r_pending & r_mieEn;
  assign w_req    = r_mstatMie && (|w_enPend);

  // Priority encoder: scanning from the top down leaves the lowest set index.
  always_comb begin
    w_sel = 4'd0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (w_enPend[i]) w_sel = 4'(i);
    end
  end

  // MRET owns the cycle it executes in, so it blocks trap acceptance.
  assign w_taken = bus.int_check && w_req && !bus.mret_exec;

  // Vectored mode offsets the base by 4 bytes per source index.
  assign w_base = {r_mtvec[31:2], 2'b00};

  assign bus.int_taken   = w_taken;
  assign bus.trap_target = r_mtvec[0] ? (w_base + {26'b0, w_sel, 2'b00}) : w_base;
  assign bus.mepc_out    = r_mepc;
  assign bus.mie_global  = r_mstatMie;

  // Edge detection and the two clear sources; the trap clear and the mip
  // W1C clear are OR-combined, and a fresh rising edge overrides both.
  assign w_rise    = i_irq_in & ~r_irqPrev;
  assign w_trapClr = w_taken ? (NUM_IRQ'(1) << w_sel) : '0;
  assign w_w1cClr  = w_wrMip ? bus.csr_wd[NUM_IRQ-1:0] : '0;

  // Combinational CSR read of pre-edge state; unimplemented addresses read 0.
  always_comb begin
    w_csrRd = 32'd0;
    case (bus.csr_addr)
      ADDR_MSTATUS: begin
        w_csrRd[3] = r_mstatMie;
        w_csrRd[7] = r_mstatMpie;
      end
      ADDR_MIE:    w_csrRd[NUM_IRQ-1:0] = r_mieEn;
      ADDR_MTVEC:  w_csrRd = r_mtvec;
      ADDR_MEPC:   w_csrRd = r_mepc;
      ADDR_MCAUSE: w_csrRd = r_mcause;
      ADDR_MIP:    w_csrRd[NUM_IRQ-1:0] = r_pending;
      default:     w_csrRd = 32'd0;
    endcase
  end

  assign bus.csr_rd = w_csrRd;

  // mstatus: a trap stacks MIE into MPIE, MRET unstacks it; both outrank
  // a software write to mstatus in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mstatMie  <= 1'b0;
      r_mstatMpie <= 1'b0;
    end else if (w_taken) begin
      r_mstatMpie <= r_mstatMie;
      r_mstatMie  <= 1'b0;
    end else if (bus.mret_exec) begin
      r_mstatMie  <= r_mstatMpie;
      r_mstatMpie <= 1'b1;
    end else if (w_wrMstatus) begin
      r_mstatMie  <= bus.csr_wd[3];
      r_mstatMpie <= bus.csr_wd[7];
    end
  end

  // mepc and mcause capture trap context; a same-cycle write loses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mepc   <= 32'd0;
      r_mcause <= 32'd0;
    end else begin
      if (w_taken)       r_mepc <= bus.pc & 32'hFFFF_FFFC;
      else if (w_wrMepc) r_mepc <= bus.csr_wd & 32'hFFFF_FFFC;
      if (w_taken)         r_mcause <= {1'b1, 27'b0, w_sel};
      else if (w_wrMcause) r_mcause <= bus.csr_wd;
    end
  end

  // mie and mtvec are plain software registers; mtvec bit1 is hardwired 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mieEn <= '0;
      r_mtvec <= MTVEC_RESET;
    end else begin
      if (w_wrMie)   r_mieEn <= bus.csr_wd[NUM_IRQ-1:0];
      if (w_wrMtvec) r_mtvec <= bus.csr_wd & 32'hFFFF_FFFD;
    end
  end

  // Pending bits latch rising edges of the level inputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_irqPrev <= '0;
      r_pending <= '0;
    end else begin
      r_irqPrev <= i_irq_in;
      r_pending <= (r_pending & ~(w_trapClr | w_w1cClr)) | w_rise;
    end
  end

endmodule
